// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
//   Fetch / decode / execute sequencer for the 16-bit core. It drives every
//   control of the 8-entry register file (r0 is the PC), the write-data
//   source mux, the external ALU opcode, the LDI immediate and the memory
//   request handshake. Memory is always addressed by the register file read
//   port, so addressing is steered through src_sel.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   mem_req    memory request, held until mem_ready
//   mem_we     1 = write (ST), valid with mem_req
//   mem_ready  memory completes the request this cycle (read data valid)
//   mem_rdata  instruction or load data
//   src_sel    register file source / address select
//   dst_sel    register file destination select
//   in_en      register file write enable
//   out_en     register file output enable (address/data drive)
//   pc_inc     increment r0 this cycle
//   in_sel     write-data mux: 0 ALU, 1 mem_rdata, 2 imm
//   alu_op     0 PASS_SRC, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
//   imm        sign-extended ir[8:0]
//   halted     core stopped by HLT
//   illegal    one-cycle pulse on an undefined opcode
module cpu_control_fsm #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        src_sel,
  output logic [2:0]        dst_sel,
  output logic              in_en,
  output logic              out_en,
  output logic              pc_inc,
  output logic [1:0]        in_sel,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ir_reg, ir_next;

  logic [3:0]        op;
  logic [2:0]        dst_f;
  logic [2:0]        src_f;
  logic [DATA_W-1:0] imm_ext;
  logic [2:0]        alu_dec;

  assign op      = ir_reg[15:12];
  assign dst_f   = ir_reg[11:9];
  assign src_f   = ir_reg[8:6];
  assign imm_ext = {{(DATA_W-IMM_W){ir_reg[IMM_W-1]}}, ir_reg[IMM_W-1:0]};

  // MOV maps onto PASS_SRC (0); non-ALU opcodes also leave the ALU at 0.
  always_comb begin
    alu_dec = 3'd0;
    case (op)
      OP_ADD:  alu_dec = 3'd1;
      OP_SUB:  alu_dec = 3'd2;
      OP_AND:  alu_dec = 3'd3;
      OP_OR:   alu_dec = 3'd4;
      OP_XOR:  alu_dec = 3'd5;
      default: alu_dec = 3'd0;
    endcase
  end

  // Reset acts on the state register directly, so every output (notably
  // mem_req) falls the moment rst goes low, even mid-wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_RESET;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    src_sel    = 3'd0;
    dst_sel    = 3'd0;
    in_en      = 1'b0;
    out_en     = 1'b0;
    pc_inc     = 1'b0;
    in_sel     = 2'd0;
    alu_op     = 3'd0;
    imm        = '0;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      S_RESET: begin
        state_next = S_FETCH;
      end

      // Address comes from r0 (src_sel=0). The PC only advances in the
      // completing cycle, so a jump written in EXEC/MEM is fetched as-is.
      S_FETCH: begin
        mem_req = 1'b1;
        out_en  = 1'b1;
        if (mem_ready) begin
          pc_inc     = 1'b1;
          ir_next    = mem_rdata;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        src_sel = src_f;
        dst_sel = dst_f;
        alu_op  = alu_dec;
        imm     = imm_ext;
        if (op == OP_HLT) begin
          state_next = S_HALT;
        end else if (op == OP_LD || op == OP_ST) begin
          state_next = S_MEM;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        src_sel    = src_f;
        dst_sel    = dst_f;
        alu_op     = alu_dec;
        imm        = imm_ext;
        state_next = S_FETCH;
        case (op)
          OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            in_en  = 1'b1;
            in_sel = 2'd0;
          end
          OP_LDI: begin
            in_en  = 1'b1;
            in_sel = 2'd2;
          end
          OP_NOP: begin
          end
          // Only A-E can reach here besides the cases above.
          default: illegal = 1'b1;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_ST);
        src_sel = src_f;
        dst_sel = dst_f;
        out_en  = 1'b1;
        if (mem_ready) begin
          if (op == OP_LD) begin
            in_en  = 1'b1;
            in_sel = 2'd1;
          end
          state_next = S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  src_sel;
    logic [2:0]  dst_sel;
    logic        in_en;
    logic        out_en;
    logic        pc_inc;
    logic [1:0]  in_sel;
    logic [2:0]  alu_op;
    logic [15:0] imm;
    logic        halted;
    logic        illegal;
  } outs_t;

  typedef struct {
    logic        rst_v;
    logic        rdy;
    logic [15:0] rdata;
    outs_t       exp;
    string       tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_req, mem_we, in_en, out_en, pc_inc, halted, illegal;
  logic [2:0]  src_sel, dst_sel, alu_op;
  logic [1:0]  in_sel;
  logic [15:0] imm;

  cpu_control_fsm #(.DATA_W(16), .IMM_W(9)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .src_sel(src_sel), .dst_sel(dst_sel), .in_en(in_en), .out_en(out_en),
    .pc_inc(pc_inc), .in_sel(in_sel), .alu_op(alu_op), .imm(imm),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = {mem_req, mem_we, src_sel, dst_sel, in_en, out_en, pc_inc,
                in_sel, alu_op, imm, halted, illegal};

  int    n_checks = 0;
  int    n_fail   = 0;
  outs_t sb[$];
  vec_t  vecs[$];

  function automatic outs_t mk(input logic req, input logic we,
                               input logic [2:0] s, input logic [2:0] d,
                               input logic ie, input logic oe, input logic pc,
                               input logic [1:0] isel, input logic [2:0] alu,
                               input logic [15:0] im, input logic h, input logic il);
    outs_t o;
    o.mem_req = req; o.mem_we = we; o.src_sel = s; o.dst_sel = d;
    o.in_en = ie; o.out_en = oe; o.pc_inc = pc; o.in_sel = isel;
    o.alu_op = alu; o.imm = im; o.halted = h; o.illegal = il;
    return o;
  endfunction

  // Expected FETCH outputs: request from r0, pc_inc only when memory completes.
  function automatic outs_t fx(input logic rdy);
    return mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, rdy, 2'd0, 3'd0, 16'h0000, 1'b0, 1'b0);
  endfunction

  function automatic outs_t zero_o();
    return mk(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 1'b0);
  endfunction

  task automatic add(input logic r, input logic rdy, input logic [15:0] d,
                     input outs_t e, input string tag);
    vec_t v;
    v.rst_v = r; v.rdy = rdy; v.rdata = d; v.exp = e; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag);
    outs_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, act);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", tag, act, e);
      end else begin
        $display("ok   %s: %h", tag, act);
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic r, input logic rdy, input logic [15:0] d,
                      input outs_t e, input string tag);
    @(negedge clk);
    rst       = r;
    mem_ready = rdy;
    mem_rdata = d;
    sb.push_back(e);
    #1;
    check(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b0;

    // reset and release
    add(1'b0, 1'b0, 16'h0000, zero_o(), "reset_a");
    add(1'b0, 1'b1, 16'h7405, zero_o(), "reset_rdy_ignored");
    add(1'b1, 1'b0, 16'h0000, zero_o(), "reset_release");

    // LDI r2,5
    add(1'b1, 1'b1, 16'h7405, fx(1'b1), "ldi_fetch");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd0,3'd2,0,0,0,2'd0,3'd0,16'h0005,0,0), "ldi_decode");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd0,3'd2,1,0,0,2'd2,3'd0,16'h0005,0,0), "ldi_exec");

    // LDI r3,-1
    add(1'b1, 1'b1, 16'h77FF, fx(1'b1), "ldim1_fetch");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd7,3'd3,0,0,0,2'd0,3'd0,16'hFFFF,0,0), "ldim1_decode");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd7,3'd3,1,0,0,2'd2,3'd0,16'hFFFF,0,0), "ldim1_exec");

    // ADD r3,r1 with two wait cycles; ready in DECODE is ignored
    add(1'b1, 1'b0, 16'hDEAD, fx(1'b0), "add_fetch_w1");
    add(1'b1, 1'b0, 16'hBEEF, fx(1'b0), "add_fetch_w2");
    add(1'b1, 1'b1, 16'h2650, fx(1'b1), "add_fetch_rdy");
    add(1'b1, 1'b1, 16'hFFFF, mk(0,0,3'd1,3'd3,0,0,0,2'd0,3'd1,16'h0050,0,0), "add_decode");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd1,3'd3,1,0,0,2'd0,3'd1,16'h0050,0,0), "add_exec");

    // LD r4,[r2] with one wait cycle
    add(1'b1, 1'b1, 16'h8880, fx(1'b1), "ld_fetch");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd2,3'd4,0,0,0,2'd0,3'd0,16'h0080,0,0), "ld_decode");
    add(1'b1, 1'b0, 16'h0000, mk(1,0,3'd2,3'd4,0,1,0,2'd0,3'd0,16'h0000,0,0), "ld_mem_wait");
    add(1'b1, 1'b1, 16'h1234, mk(1,0,3'd2,3'd4,1,1,0,2'd1,3'd0,16'h0000,0,0), "ld_mem_rdy");

    // ST [r2],r4 with one wait cycle
    add(1'b1, 1'b1, 16'h9880, fx(1'b1), "st_fetch");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd2,3'd4,0,0,0,2'd0,3'd0,16'h0080,0,0), "st_decode");
    add(1'b1, 1'b0, 16'h0000, mk(1,1,3'd2,3'd4,0,1,0,2'd0,3'd0,16'h0000,0,0), "st_mem_wait");
    add(1'b1, 1'b1, 16'h0000, mk(1,1,3'd2,3'd4,0,1,0,2'd0,3'd0,16'h0000,0,0), "st_mem_rdy");

    // MOV r0,r5 (jump); imm field 0x140 sign-extends to 0xFF40
    add(1'b1, 1'b1, 16'h1140, fx(1'b1), "mov_fetch");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd5,3'd0,0,0,0,2'd0,3'd0,16'hFF40,0,0), "mov_decode");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd5,3'd0,1,0,0,2'd0,3'd0,16'hFF40,0,0), "mov_exec");

    // SUB r1,r2 and XOR r1,r2
    add(1'b1, 1'b1, 16'h3280, fx(1'b1), "sub_fetch");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd2,3'd1,0,0,0,2'd0,3'd2,16'h0080,0,0), "sub_decode");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd2,3'd1,1,0,0,2'd0,3'd2,16'h0080,0,0), "sub_exec");
    add(1'b1, 1'b1, 16'h6280, fx(1'b1), "xor_fetch");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd2,3'd1,0,0,0,2'd0,3'd5,16'h0080,0,0), "xor_decode");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd2,3'd1,1,0,0,2'd0,3'd5,16'h0080,0,0), "xor_exec");

    // NOP: no enables anywhere
    add(1'b1, 1'b1, 16'h0000, fx(1'b1), "nop_fetch");
    add(1'b1, 1'b0, 16'h0000, zero_o(), "nop_decode");
    add(1'b1, 1'b0, 16'h0000, zero_o(), "nop_exec");

    // illegal 0xB000: single-cycle pulse, then back to FETCH
    add(1'b1, 1'b1, 16'hB000, fx(1'b1), "ill_fetch");
    add(1'b1, 1'b0, 16'h0000, zero_o(), "ill_decode");
    add(1'b1, 1'b0, 16'h0000, mk(0,0,3'd0,3'd0,0,0,0,2'd0,3'd0,16'h0000,0,1), "ill_exec");
    add(1'b1, 1'b0, 16'h0000, fx(1'b0), "ill_next_fetch");

    foreach (vecs[i]) step(vecs[i].rst_v, vecs[i].rdy, vecs[i].rdata, vecs[i].exp, vecs[i].tag);

    // reset during an LD memory wait: request drops at once, no write
    step(1'b1, 1'b1, 16'h8880, fx(1'b1), "rld_fetch");
    step(1'b1, 1'b0, 16'h0000, mk(0,0,3'd2,3'd4,0,0,0,2'd0,3'd0,16'h0080,0,0), "rld_decode");
    step(1'b1, 1'b0, 16'h0000, mk(1,0,3'd2,3'd4,0,1,0,2'd0,3'd0,16'h0000,0,0), "rld_mem_wait");
    step(1'b0, 1'b1, 16'h5555, zero_o(), "rld_reset_mid_wait");
    step(1'b1, 1'b1, 16'h5555, zero_o(), "rld_release");
    step(1'b1, 1'b0, 16'h0000, fx(1'b0), "rld_first_fetch");

    // HLT: halted stays set, no memory request, ready ignored
    step(1'b1, 1'b1, 16'hF000, fx(1'b1), "hlt_fetch");
    step(1'b1, 1'b0, 16'h0000, zero_o(), "hlt_decode");
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom),
           mk(0,0,3'd0,3'd0,0,0,0,2'd0,3'd0,16'h0000,1,0), $sformatf("halt_%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
